hack_ram: RTL and testbench

Parametrised single-write, dual-read RAM for the Hack computer. It replaces the fixed 16K×16 data RAM and also serves screen memory, where port B feeds the display scanner. It adds three things:
- a hardware clear sequencer that zeroes the array after every reset, instead of relying on simulation-only initialisation;
- a selectable read latency;
- a second, read-only port.

---
 rtl/hack_mem_pkg.sv | 15 +
 rtl/hack_ram_clear_seq.sv | 49 ++++
 rtl/hack_ram.sv | 88 ++++++++
 tb/tb_hack_ram.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_mem_pkg.sv
// Shared definitions for the Hack data and screen RAMs: sweep FSM state
// encoding and the default geometry of both memories.
package hack_mem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clear_state_e;

  localparam int DATA_RAM_WIDTH    = 16;
  localparam int DATA_RAM_ADDR_W   = 14;
  localparam int SCREEN_RAM_WIDTH  = 16;
  localparam int SCREEN_RAM_ADDR_W = 13;

endpackage

// File: rtl/hack_ram_clear_seq.sv
// Post-reset clear sweep: walks every address once, writing CLEAR_VALUE,
// and holds busy high until the last location has been written.
module hack_ram_clear_seq
  import hack_mem_pkg::*;
#(
  parameter int                ADDR_W      = DATA_RAM_ADDR_W,
  parameter int                WIDTH       = DATA_RAM_WIDTH,
  parameter logic [WIDTH-1:0]  CLEAR_VALUE = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o,
  output logic [WIDTH-1:0]  clr_data_o,
  output logic              busy_o
);

  clear_state_e      state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // The pointer wraps to zero naturally on the edge that writes the top address.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_CLEAR) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == {ADDR_W{1'b1}}) begin
        state_d = ST_READY;
      end
    end
  end

  // busy comes straight from the state flop, so it cannot glitch.
  assign busy_o     = (state_q == ST_CLEAR);
  assign clr_we_o   = (state_q == ST_CLEAR);
  assign clr_addr_o = ptr_q;
  assign clr_data_o = CLEAR_VALUE;

endmodule

// File: rtl/hack_ram.sv
// Single-write, dual-read RAM for the Hack computer with a hardware clear
// sweep after reset and a selectable (0 or 1 edge) read latency.
module hack_ram
  import hack_mem_pkg::*;
#(
  parameter int                WIDTH       = DATA_RAM_WIDTH,
  parameter int                ADDR_W      = DATA_RAM_ADDR_W,
  parameter int                READ_LAT    = 0,
  parameter logic [WIDTH-1:0]  CLEAR_VALUE = '0
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic signed [WIDTH-1:0]  in,
  input  logic        [ADDR_W-1:0] address,
  input  logic                     load,
  output logic signed [WIDTH-1:0]  out,
  input  logic        [ADDR_W-1:0] address_b,
  output logic signed [WIDTH-1:0]  out_b,
  output logic                     busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic              clrWe;
  logic [ADDR_W-1:0] clrAddr;
  logic [WIDTH-1:0]  clrData;
  logic              memWe;
  logic [ADDR_W-1:0] memWaddr;
  logic [WIDTH-1:0]  memWdata;
  logic [WIDTH-1:0]  mem [DEPTH];

  hack_ram_clear_seq #(
    .ADDR_W      (ADDR_W),
    .WIDTH       (WIDTH),
    .CLEAR_VALUE (CLEAR_VALUE)
  ) u_clear_seq (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .clr_we_o   (clrWe),
    .clr_addr_o (clrAddr),
    .clr_data_o (clrData),
    .busy_o     (busy)
  );

  // The sweep owns the write port while busy; port A writes are simply dropped.
  always_comb begin
    memWe    = load;
    memWaddr = address;
    memWdata = in;
    if (busy) begin
      memWe    = clrWe;
      memWaddr = clrAddr;
      memWdata = clrData;
    end
  end

  always_ff @(posedge CLK) begin
    if (memWe) begin
      mem[memWaddr] <= memWdata;
    end
  end

  generate
    if (READ_LAT == 0) begin : g_comb_read
      assign out   = busy ? CLEAR_VALUE : mem[address];
      assign out_b = busy ? CLEAR_VALUE : mem[address_b];
    end else if (READ_LAT == 1) begin : g_reg_read
      logic [WIDTH-1:0] rdA_q, rdB_q;

      // Registered reads sample the pre-edge array, giving read-before-write.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          rdA_q <= CLEAR_VALUE;
          rdB_q <= CLEAR_VALUE;
        end else begin
          rdA_q <= busy ? CLEAR_VALUE : mem[address];
          rdB_q <= busy ? CLEAR_VALUE : mem[address_b];
        end
      end

      assign out   = rdA_q;
      assign out_b = rdB_q;
    end else begin : g_bad_lat
      $error("hack_ram: READ_LAT must be 0 or 1");
    end
  endgenerate

endmodule

// File: tb/tb_hack_ram.sv
// Self-checking bench for hack_ram: two instances (READ_LAT 0 and 1) share
// stimulus and are compared against an abstract word-array reference model.
module tb_hack_ram;

  localparam int W  = 16;
  localparam int AW = 4;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rstN;
  logic [W-1:0]  inData;
  logic [AW-1:0] addrA;
  logic [AW-1:0] addrB;
  logic          loadA;
  logic [W-1:0]  out0A, out0B, out1A, out1B;
  logic          busy0, busy1;

  int errors = 0;
  int checks = 0;

  // Reference model: words visible to the CPU, and edges since reset release.
  logic [W-1:0] model [N];
  int           edges;
  logic [W-1:0] exp0A, exp0B, exp1A, exp1B;
  logic         expBusy;

  always #5 clk = ~clk;

  hack_ram #(.WIDTH(W), .ADDR_W(AW), .READ_LAT(0), .CLEAR_VALUE('0)) u_lat0 (
    .CLK(clk), .RST_N(rstN), .in(inData), .address(addrA), .load(loadA),
    .out(out0A), .address_b(addrB), .out_b(out0B), .busy(busy0)
  );

  hack_ram #(.WIDTH(W), .ADDR_W(AW), .READ_LAT(1), .CLEAR_VALUE('0)) u_lat1 (
    .CLK(clk), .RST_N(rstN), .in(inData), .address(addrA), .load(loadA),
    .out(out1A), .address_b(addrB), .out_b(out1B), .busy(busy1)
  );

  // One rising edge; expected outputs are derived from the model afterwards.
  task automatic tick();
    logic [W-1:0] preA, preB;
    preA = (edges < N) ? '0 : model[addrA];
    preB = (edges < N) ? '0 : model[addrB];
    if (edges >= N && loadA) model[addrA] = inData;
    @(posedge clk);
    if (edges < N) edges++;
    #1;
    expBusy = (edges < N);
    exp1A   = preA;
    exp1B   = preB;
    exp0A   = expBusy ? '0 : model[addrA];
    exp0B   = expBusy ? '0 : model[addrB];
  endtask

  // Asynchronous reset pulse placed between edges; contents become all-zero.
  task automatic pulseReset();
    rstN = 1'b0;
    #1;
    checks++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_busy: got %b/%b expected 1/1", busy0, busy1);
    end
    checks++;
    if (out1A !== '0 || out1B !== '0) begin
      errors++;
      $display("[TB] FAIL reset_regout: got %h/%h expected 0000/0000", out1A, out1B);
    end
    rstN = 1'b1;
    for (int i = 0; i < N; i++) model[i] = '0;
    edges = 0;
  endtask

  task automatic test_reset();
    pulseReset();
    checks++;
    if (out0A !== '0 || out0B !== '0) begin
      errors++;
      $display("[TB] FAIL reset_combout: got %h/%h expected 0000/0000", out0A, out0B);
    end
  endtask

  task automatic test_busy_count(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      checks++;
      if (busy1 !== busy0 || busy0 !== expBusy) begin
        errors++;
        $display("[TB] FAIL %s_busy: got %b/%b expected %b", name, busy0, busy1, expBusy);
      end
      if (!busy0) break;
    end
    checks++;
    if (n != N || busy0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_edges: got %0d edges (busy=%b) expected %0d", name, n, busy0, N);
    end
  endtask

  task automatic test_all_zero(input string name);
    loadA = 1'b0;
    for (int a = 0; a < N; a++) begin
      addrA = AW'(a);
      addrB = AW'(N - 1 - a);
      tick();
      checks++;
      if (out0A !== 16'h0 || out0B !== 16'h0 || out1A !== 16'h0 || out1B !== 16'h0) begin
        errors++;
        $display("[TB] FAIL %s_a%0d: got %h %h %h %h expected all 0000",
                 name, a, out0A, out0B, out1A, out1B);
      end
    end
  endtask

  task automatic test_dropped_write();
    loadA = 1'b1;
    inData = 16'h7FFF;
    for (int a = 0; a < N; a++) begin
      addrA = AW'(a);
      tick();
    end
    loadA = 1'b0;
    addrA = 4'd3;
    addrB = 4'd3;
    tick();
    checks++;
    if (out0A !== 16'h7FFF || out1A !== 16'h7FFF) begin
      errors++;
      $display("[TB] FAIL preload: got %h/%h expected 7fff/7fff", out0A, out1A);
    end
    pulseReset();
    loadA = 1'b1;
    inData = 16'h1234;
    addrA = 4'd3;
    for (int i = 0; i < N; i++) begin
      tick();
      checks++;
      if (out0A !== 16'h0 || out1A !== 16'h0) begin
        errors++;
        $display("[TB] FAIL sweep_out: got %h/%h expected 0000/0000", out0A, out1A);
      end
    end
    checks++;
    if (busy0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sweep_done: got busy=%b expected 0", busy0);
    end
    loadA = 1'b0;
    test_all_zero("dropped");
  endtask

  task automatic test_write_neg();
    addrA = 4'd9;
    addrB = 4'd9;
    inData = 16'hFFFB;
    loadA = 1'b1;
    tick();
    loadA = 1'b0;
    checks++;
    if (out0A !== 16'hFFFB || out0B !== 16'hFFFB) begin
      errors++;
      $display("[TB] FAIL wr_lat0: got %h/%h expected fffb/fffb", out0A, out0B);
    end
    checks++;
    if (out1A !== 16'h0 || out1B !== 16'h0) begin
      errors++;
      $display("[TB] FAIL wr_lat1_old: got %h/%h expected 0000/0000", out1A, out1B);
    end
    tick();
    checks++;
    if (out1A !== 16'hFFFB || out1B !== 16'hFFFB) begin
      errors++;
      $display("[TB] FAIL wr_lat1_new: got %h/%h expected fffb/fffb", out1A, out1B);
    end
  endtask

  task automatic test_collision();
    addrA = 4'd2;
    addrB = 4'd2;
    inData = 16'h0011;
    loadA = 1'b1;
    tick();
    inData = 16'h0022;
    tick();
    loadA = 1'b0;
    checks++;
    if (out1B !== 16'h0011 || out1A !== 16'h0011) begin
      errors++;
      $display("[TB] FAIL coll_old: got %h/%h expected 0011/0011", out1A, out1B);
    end
    checks++;
    if (out0B !== 16'h0022) begin
      errors++;
      $display("[TB] FAIL coll_lat0: got %h expected 0022", out0B);
    end
    tick();
    checks++;
    if (out1B !== 16'h0022 || out1A !== 16'h0022) begin
      errors++;
      $display("[TB] FAIL coll_new: got %h/%h expected 0022/0022", out1A, out1B);
    end
  endtask

  task automatic test_mid_sweep_reset();
    pulseReset();
    for (int i = 0; i < 7; i++) tick();
    pulseReset();
    test_busy_count("midreset");
  endtask

  task automatic test_sign_edges();
    int v;
    loadA = 1'b1;
    addrA = 4'd0;  inData = 16'h8000; tick();
    addrA = 4'd15; inData = 16'h7FFF; tick();
    loadA = 1'b0;
    addrA = 4'd0;
    addrB = 4'd15;
    tick();
    tick();
    v = $signed(out1A);
    checks++;
    if (v != -32768 || out0A !== 16'h8000) begin
      errors++;
      $display("[TB] FAIL sign_a0: got %0d/%h expected -32768/8000", v, out0A);
    end
    v = $signed(out1B);
    checks++;
    if (v != 32767 || out0B !== 16'h7FFF) begin
      errors++;
      $display("[TB] FAIL sign_a15: got %0d/%h expected 32767/7fff", v, out0B);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      loadA  = 1'($urandom_range(0, 1));
      addrA  = AW'($urandom_range(0, N - 1));
      addrB  = ($urandom_range(0, 3) == 0) ? addrA : AW'($urandom_range(0, N - 1));
      inData = W'($urandom);
      tick();
      checks++;
      if (out0A !== exp0A || out0B !== exp0B || out1A !== exp1A || out1B !== exp1B ||
          busy0 !== expBusy || busy1 !== expBusy) begin
        errors++;
        $display("[TB] FAIL random_%0d: got %h %h %h %h b%b%b expected %h %h %h %h b%b",
                 i, out0A, out0B, out1A, out1B, busy0, busy1,
                 exp0A, exp0B, exp1A, exp1B, expBusy);
      end
    end
    loadA = 1'b0;
  endtask

  initial begin
    rstN = 1'b1;
    inData = '0;
    addrA = '0;
    addrB = '0;
    loadA = 1'b0;
    edges = 0;
    for (int i = 0; i < N; i++) model[i] = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_busy_count("release");
    test_all_zero("initial");
    test_dropped_write();
    test_write_neg();
    test_collision();
    test_mid_sweep_reset();
    test_sign_edges();
    test_random();
    pulseReset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
